vc_rr_arb_buf: RTL and testbench

VC_RR_ARB_BUF -- requirements
Module: vc_rr_arb_buf

---
 rtl/vc_rr_arb_buf_pkg.sv | 28 ++
 rtl/vc_VariableArbChain.sv | 38 +++
 rtl/vc_rr_arb_buf_fifo.sv | 85 ++++++++
 rtl/vc_rr_arb_buf.sv | 154 +++++++++++++++
 tb/tb_vc_rr_arb_buf.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_rr_arb_buf_pkg.sv
// Shared definitions for the round-robin arbitrated input buffer.
// Holds the per-input FIFO geometry and the one-hot rotate helper used to
// advance the arbitration priority.
package vc_rr_arb_buf_pkg;

  // Per-input FIFO geometry
  localparam int unsigned c_fifo_depth     = 32'd2;
  localparam int unsigned c_fifo_ptr_nbits = 32'd1;
  localparam int unsigned c_fifo_cnt_nbits = 32'd2;

  // Widest requester vector the rotate helper handles
  localparam int unsigned c_max_reqs = 32'd8;

  // Rotate the low nbits of a one-hot vector left by one; bit nbits-1 wraps to bit 0.
  function automatic logic [7:0] rotl_onehot(input logic [7:0] vec, input int unsigned nbits);
    logic [7:0] rot;
    rot = 8'd0;
    for (int unsigned i = 32'd0; i < c_max_reqs; i++) begin
      if (i < nbits) begin
        rot[3'((i + 32'd1) % nbits)] = vec[3'(i)];
      end else begin
        rot = rot;
      end
    end
    return rot;
  endfunction

endpackage

// File: rtl/vc_VariableArbChain.sv
// Variable-priority arbitration chain. The one-hot prio vector marks the
// highest-priority requester; the first requester at or above it (wrapping)
// wins. kin kills every grant; kout reports that a grant (or kill) happened.
module vc_VariableArbChain #(
  parameter int p_num_reqs = 2
) (
  input  logic                  kin,
  input  logic [p_num_reqs-1:0] prio,
  input  logic [p_num_reqs-1:0] reqs,
  output logic [p_num_reqs-1:0] grants,
  output logic                  kout
);

  logic found_s;
  logic started_s;

  // Walk the requesters twice so the search wraps past the top index.
  always_comb begin
    grants    = '0;
    found_s   = kin;
    started_s = 1'b0;
    for (int i = 0; i < 2 * p_num_reqs; i++) begin
      if ((i < p_num_reqs) && prio[i % p_num_reqs]) begin
        started_s = 1'b1;
      end else begin
        started_s = started_s;
      end
      if (started_s && !found_s && reqs[i % p_num_reqs]) begin
        grants[i % p_num_reqs] = 1'b1;
        found_s                = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    kout = found_s;
  end

endmodule

// File: rtl/vc_rr_arb_buf_fifo.sv
// Two-entry val/rdy FIFO used on each arbiter input. enq_rdy depends only on
// the stored occupancy, never on a same-cycle dequeue, so there is no bypass
// from enq to deq and no combinational path from deq_rdy to enq_rdy.
module vc_rr_arb_buf_fifo
  import vc_rr_arb_buf_pkg::*;
#(
  parameter int p_msg_nbits = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg
);

  logic [p_msg_nbits-1:0]      mem_q  [c_fifo_depth];
  logic [p_msg_nbits-1:0]      mem_d  [c_fifo_depth];
  logic [c_fifo_ptr_nbits-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_fifo_ptr_nbits-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_fifo_cnt_nbits-1:0] count_q, count_d;
  logic                        enq_fire_s;
  logic                        deq_fire_s;

  assign enq_rdy = (count_q != c_fifo_cnt_nbits'(c_fifo_depth));
  assign deq_val = (count_q != {c_fifo_cnt_nbits{1'b0}});
  assign deq_msg = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    enq_fire_s = enq_val && enq_rdy;
    deq_fire_s = deq_val && deq_rdy;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (enq_fire_s) begin
      mem_d[wr_ptr_q] = enq_msg;
      if (wr_ptr_q == c_fifo_ptr_nbits'(c_fifo_depth - 32'd1)) begin
        wr_ptr_d = {c_fifo_ptr_nbits{1'b0}};
      end else begin
        wr_ptr_d = wr_ptr_q + c_fifo_ptr_nbits'(1);
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (deq_fire_s) begin
      if (rd_ptr_q == c_fifo_ptr_nbits'(c_fifo_depth - 32'd1)) begin
        rd_ptr_d = {c_fifo_ptr_nbits{1'b0}};
      end else begin
        rd_ptr_d = rd_ptr_q + c_fifo_ptr_nbits'(1);
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({enq_fire_s, deq_fire_s})
      2'b10:   count_d = count_q + c_fifo_cnt_nbits'(1);
      2'b01:   count_d = count_q - c_fifo_cnt_nbits'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < c_fifo_depth; i++) begin
        mem_q[i] <= {p_msg_nbits{1'b0}};
      end
      wr_ptr_q <= {c_fifo_ptr_nbits{1'b0}};
      rd_ptr_q <= {c_fifo_ptr_nbits{1'b0}};
      count_q  <= {c_fifo_cnt_nbits{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vc_rr_arb_buf.sv
// Round-robin arbiter with a 2-entry buffer per input and a single output
// register. Minimum latency is two cycles (input FIFO, then output register)
// and the output sustains one message per cycle while out_rdy stays high.
// Optional feature: define VC_RR_ARB_BUF_CNT_EN to add the 16-bit wrapping
// out_count transfer counter.
module vc_rr_arb_buf
  import vc_rr_arb_buf_pkg::*;
#(
  parameter int p_num_reqs  = 2,
  parameter int p_msg_nbits = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              domain,
  input  logic [p_num_reqs-1:0]             in_val,
  output logic [p_num_reqs-1:0]             in_rdy,
  input  logic [p_num_reqs*p_msg_nbits-1:0] in_msg,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [p_msg_nbits-1:0]            out_msg,
  output logic [p_num_reqs-1:0]             out_src
`ifdef VC_RR_ARB_BUF_CNT_EN
  ,
  output logic [15:0]                       out_count
`endif
);

  logic [p_num_reqs-1:0]  fifo_val_s;
  logic [p_msg_nbits-1:0] fifo_msg_s [p_num_reqs];
  logic [p_num_reqs-1:0]  arb_reqs_s;
  logic [p_num_reqs-1:0]  grants_s;
  logic                   arb_en_s;
  logic                   gnt_any_s;
  logic [p_msg_nbits-1:0] gnt_msg_s;
  logic [7:0]             rot_s;
  logic                   kout_unused;
  logic                   domain_unused;

  logic                   out_val_q, out_val_d;
  logic [p_msg_nbits-1:0] out_msg_q, out_msg_d;
  logic [p_num_reqs-1:0]  out_src_q, out_src_d;
  logic [p_num_reqs-1:0]  prio_q, prio_d;

  // The domain label only classifies the data; it steers no logic here.
  assign domain_unused = domain;

  for (genvar g = 0; g < p_num_reqs; g++) begin : g_fifo
    vc_rr_arb_buf_fifo #(
      .p_msg_nbits (p_msg_nbits)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .enq_val (in_val[g]),
      .enq_rdy (in_rdy[g]),
      .enq_msg (in_msg[g*p_msg_nbits +: p_msg_nbits]),
      .deq_val (fifo_val_s[g]),
      .deq_rdy (grants_s[g]),
      .deq_msg (fifo_msg_s[g])
    );
  end

  // Requests are presented only when the output register can accept a message.
  always_comb begin
    arb_en_s = !out_val_q || out_rdy;
    if (arb_en_s) begin
      arb_reqs_s = fifo_val_s;
    end else begin
      arb_reqs_s = {p_num_reqs{1'b0}};
    end
  end

  vc_VariableArbChain #(
    .p_num_reqs (p_num_reqs)
  ) u_arb (
    .kin    (1'b0),
    .prio   (prio_q),
    .reqs   (arb_reqs_s),
    .grants (grants_s),
    .kout   (kout_unused)
  );

  // Select the granted FIFO head and compute next output/priority state.
  always_comb begin
    gnt_any_s = |grants_s;
    gnt_msg_s = {p_msg_nbits{1'b0}};
    for (int i = 0; i < p_num_reqs; i++) begin
      if (grants_s[i]) begin
        gnt_msg_s = gnt_msg_s | fifo_msg_s[i];
      end else begin
        gnt_msg_s = gnt_msg_s;
      end
    end
    rot_s = rotl_onehot(8'(grants_s), p_num_reqs);

    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    out_src_d = out_src_q;
    prio_d    = prio_q;
    if (gnt_any_s) begin
      out_val_d = 1'b1;
      out_msg_d = gnt_msg_s;
      out_src_d = grants_s;
      prio_d    = rot_s[p_num_reqs-1:0];
    end else if (out_val_q && out_rdy) begin
      out_val_d = 1'b0;
    end else begin
      out_val_d = out_val_q;
    end
  end

  // Output register and priority with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_val_q <= 1'b0;
      out_msg_q <= {p_msg_nbits{1'b0}};
      out_src_q <= {p_num_reqs{1'b0}};
      prio_q    <= {{(p_num_reqs-1){1'b0}}, 1'b1};
    end else begin
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
      out_src_q <= out_src_d;
      prio_q    <= prio_d;
    end
  end

  assign out_val = out_val_q;
  assign out_msg = out_msg_q;
  assign out_src = out_src_q;

`ifdef VC_RR_ARB_BUF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Count output transfers, wrapping at 16 bits.
  always_comb begin
    if (out_val_q && out_rdy) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_vc_rr_arb_buf.sv
// Scoreboard bench for vc_rr_arb_buf: a 2-port/32-bit instance and a
// 4-port/8-bit instance. Expected messages are queued when stimulus is
// issued; monitors pop and compare on every output transfer.
module tb_vc_rr_arb_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic domain;

  logic [1:0]  a_in_val, a_in_rdy;
  logic [63:0] a_in_msg;
  logic        a_out_val, a_out_rdy;
  logic [31:0] a_out_msg;
  logic [1:0]  a_out_src;

  logic [3:0]  b_in_val, b_in_rdy;
  logic [31:0] b_in_msg;
  logic        b_out_val, b_out_rdy;
  logic [7:0]  b_out_msg;
  logic [3:0]  b_out_src;

`ifdef VC_RR_ARB_BUF_CNT_EN
  logic [15:0] a_out_count, b_out_count;
`endif

  vc_rr_arb_buf #(.p_num_reqs(2), .p_msg_nbits(32)) dut_a (
    .clk(clk), .reset(reset), .domain(domain),
    .in_val(a_in_val), .in_rdy(a_in_rdy), .in_msg(a_in_msg),
    .out_val(a_out_val), .out_rdy(a_out_rdy), .out_msg(a_out_msg), .out_src(a_out_src)
`ifdef VC_RR_ARB_BUF_CNT_EN
    , .out_count(a_out_count)
`endif
  );

  vc_rr_arb_buf #(.p_num_reqs(4), .p_msg_nbits(8)) dut_b (
    .clk(clk), .reset(reset), .domain(domain),
    .in_val(b_in_val), .in_rdy(b_in_rdy), .in_msg(b_in_msg),
    .out_val(b_out_val), .out_rdy(b_out_rdy), .out_msg(b_out_msg), .out_src(b_out_src)
`ifdef VC_RR_ARB_BUF_CNT_EN
    , .out_count(b_out_count)
`endif
  );

  typedef struct packed {
    logic [31:0] msg;
    logic [7:0]  src;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  bit   sb_en  = 1'b1;
  int   acc0   = 0;
  int   acc1   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 2-port instance
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && sb_en && a_out_val === 1'b1 && a_out_rdy === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: got msg 0x%0h src %b, expected no transfer", a_out_msg, a_out_src);
      end else begin
        e = qa.pop_front();
        check("a_out_msg", a_out_msg, e.msg);
        check("a_out_src", 32'(a_out_src), 32'(e.src));
      end
    end
  end

  // Monitor for the 4-port instance
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && sb_en && b_out_val === 1'b1 && b_out_rdy === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got msg 0x%0h src %b, expected no transfer", b_out_msg, b_out_src);
      end else begin
        e = qb.pop_front();
        check("b_out_msg", 32'(b_out_msg), e.msg);
        check("b_out_src", 32'(b_out_src), 32'(e.src));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset    = 1'b0;
    a_in_val = 2'b00;
    b_in_val = 4'b0000;
    tick();
    reset = 1'b1;
    qa.delete();
    qb.delete();
  endtask

  // Drive n0/n1 messages into ports 0/1 of dut_a, honouring in_rdy.
  task automatic drive_a(input int n0, input int n1, input logic [31:0] b0,
                         input logic [31:0] b1, input int max_cycles);
    int s0, s1, cyc;
    logic [1:0] fire;
    s0 = 0; s1 = 0; cyc = 0;
    acc0 = 0; acc1 = 0;
    while ((s0 < n0 || s1 < n1) && cyc < max_cycles) begin
      a_in_val = {(s1 < n1), (s0 < n0)};
      a_in_msg = {32'(b1 + 32'(s1)), 32'(b0 + 32'(s0))};
      @(negedge clk);
      fire = a_in_val & a_in_rdy;
      tick();
      if (fire[0]) s0++;
      if (fire[1]) s1++;
      acc0 = s0;
      acc1 = s1;
      cyc++;
    end
    a_in_val = 2'b00;
  endtask

  task automatic wait_drain_a(input int max_cycles);
    int n;
    n = 0;
    while ((qa.size() != 0 || a_out_val === 1'b1) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("a_drain_pending", 32'(qa.size()), 32'd0);
  endtask

  task automatic wait_drain_b(input int max_cycles);
    int n;
    n = 0;
    while ((qb.size() != 0 || b_out_val === 1'b1) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("b_drain_pending", 32'(qb.size()), 32'd0);
  endtask

  // Global time limit
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    domain    = 1'b0;
    a_in_val  = 2'b00;
    a_in_msg  = 64'd0;
    a_out_rdy = 1'b0;
    b_in_val  = 4'b0000;
    b_in_msg  = 32'd0;
    b_out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_a_out_val", 32'(a_out_val), 32'd0);
    check("rst_a_out_src", 32'(a_out_src), 32'd0);
    check("rst_a_out_msg", a_out_msg, 32'd0);
    check("rst_a_in_rdy", 32'(a_in_rdy), 32'h3);
    check("rst_a_prio", 32'(dut_a.prio_q), 32'h1);
    check("rst_b_in_rdy", 32'(b_in_rdy), 32'hF);
    check("rst_b_prio", 32'(dut_b.prio_q), 32'h1);

    // Single message on port 0, two-cycle latency
    tick();
    a_out_rdy = 1'b1;
    a_in_val  = 2'b01;
    a_in_msg  = {32'd0, 32'hA5};
    qa.push_back('{msg: 32'hA5, src: 8'h01});
    @(negedge clk);
    check("t1_lat_c0", 32'(a_out_val), 32'd0);
    tick();
    a_in_val = 2'b00;
    @(negedge clk);
    check("t1_lat_c1", 32'(a_out_val), 32'd0);
    @(negedge clk);
    check("t1_lat_c2", 32'(a_out_val), 32'd1);
    wait_drain_a(20);

    // Both ports continuously valid: alternation from port 0, one per cycle
    do_reset();
    a_out_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      qa.push_back('{msg: 32'h10 + 32'(k), src: 8'h01});
      qa.push_back('{msg: 32'h20 + 32'(k), src: 8'h02});
    end
    fork
      drive_a(8, 8, 32'h10, 32'h20, 60);
      begin
        int w, vc;
        w = 0; vc = 0;
        do begin
          @(negedge clk);
          w++;
        end while (a_out_val !== 1'b1 && w < 20);
        for (int k = 0; k < 16; k++) begin
          if (a_out_val === 1'b1) vc++;
          if (k < 15) @(negedge clk);
        end
        check("t2_back_to_back", 32'(vc), 32'd16);
      end
    join
    check("t2_acc0", 32'(acc0), 32'd8);
    check("t2_acc1", 32'(acc1), 32'd8);
    wait_drain_a(40);

    // Output stalled: FIFOs fill, output and priority hold
    do_reset();
    a_out_rdy = 1'b0;
    qa.push_back('{msg: 32'h30, src: 8'h01});
    qa.push_back('{msg: 32'h40, src: 8'h02});
    qa.push_back('{msg: 32'h31, src: 8'h01});
    qa.push_back('{msg: 32'h41, src: 8'h02});
    qa.push_back('{msg: 32'h32, src: 8'h01});
    qa.push_back('{msg: 32'h42, src: 8'h02});
    fork
      drive_a(3, 3, 32'h30, 32'h40, 40);
      begin
        repeat (6) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          check("t3_out_val", 32'(a_out_val), 32'd1);
          check("t3_out_msg_hold", a_out_msg, 32'h30);
          check("t3_out_src_hold", 32'(a_out_src), 32'h1);
          check("t3_prio_hold", 32'(dut_a.prio_q), 32'h2);
          check("t3_in_rdy_full", 32'(a_in_rdy), 32'h0);
          @(negedge clk);
        end
        check("t3_acc0_stalled", 32'(acc0), 32'd3);
        check("t3_acc1_stalled", 32'(acc1), 32'd2);
        tick();
        a_out_rdy = 1'b1;
      end
    join
    check("t3_acc1_final", 32'(acc1), 32'd3);
    wait_drain_a(30);

    // Four ports: port 3 then port 0, wrap-around priority
    do_reset();
    b_out_rdy = 1'b1;
    qb.push_back('{msg: 32'hC3, src: 8'h08});
    qb.push_back('{msg: 32'hC0, src: 8'h01});
    b_in_val = 4'b1000;
    b_in_msg = {8'hC3, 8'h00, 8'h00, 8'h00};
    tick();
    b_in_val = 4'b0001;
    b_in_msg = {8'h00, 8'h00, 8'h00, 8'hC0};
    tick();
    b_in_val = 4'b0000;
    check("t4_prio_after_p3", 32'(dut_b.prio_q), 32'h1);
    wait_drain_b(20);
    check("t4_prio_after_p0", 32'(dut_b.prio_q), 32'h2);

    // Ports 3 and 0 together with priority at port 1: 3 wins, then 0
    tick();
    qb.push_back('{msg: 32'hD3, src: 8'h08});
    qb.push_back('{msg: 32'hD0, src: 8'h01});
    b_in_val = 4'b1001;
    b_in_msg = {8'hD3, 8'h00, 8'h00, 8'hD0};
    tick();
    b_in_val = 4'b0000;
    wait_drain_b(20);
    check("t4_prio_final", 32'(dut_b.prio_q), 32'h2);

    // Reset with every buffer full discards everything
    do_reset();
    a_out_rdy = 1'b0;
    drive_a(3, 3, 32'h50, 32'h60, 12);
    @(negedge clk);
    check("t5_full_in_rdy", 32'(a_in_rdy), 32'h0);
    check("t5_full_out_val", 32'(a_out_val), 32'd1);
    do_reset();
    @(negedge clk);
    check("t5_rst_out_val", 32'(a_out_val), 32'd0);
    check("t5_rst_in_rdy", 32'(a_in_rdy), 32'h3);
    check("t5_rst_prio", 32'(dut_a.prio_q), 32'h1);
    check("t5_rst_out_src", 32'(a_out_src), 32'h0);
    check("t5_rst_out_msg", a_out_msg, 32'h0);
    tick();
    a_out_rdy = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_no_stale_out", 32'(a_out_val), 32'd0);
    tick();
    qa.push_back('{msg: 32'h77, src: 8'h02});
    a_in_val = 2'b10;
    a_in_msg = {32'h77, 32'h0};
    tick();
    a_in_val = 2'b00;
    wait_drain_a(20);

`ifdef VC_RR_ARB_BUF_CNT_EN
    // 65537 transfers wrap the counter to 1
    do_reset();
    @(negedge clk);
    check("cnt_reset", 32'(a_out_count), 32'd0);
    tick();
    sb_en     = 1'b0;
    a_out_rdy = 1'b1;
    drive_a(32769, 32768, 32'h0, 32'h0, 70000);
    repeat (10) @(negedge clk);
    check("cnt_wrap", 32'(a_out_count), 32'd1);
    sb_en = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
